// File: rtl/shifter_seq.sv
// rtl/shifter_seq.sv - multi-cycle shifter, one bit position per clock, with valid/ready handshakes
module shifter_seq #(
  parameter int DSIZE  = 16,
  parameter int OPSIZE = 3,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPSIZE-1:0] op,
  input  logic [AWIDTH-1:0] amt,
  input  logic [DSIZE-1:0]  data_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DSIZE-1:0]  f,
  output logic              c,
  output logic              z
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [OPSIZE-1:0] OP_SLL = OPSIZE'(1);
  localparam logic [OPSIZE-1:0] OP_ROR = OPSIZE'(2);
  localparam logic [OPSIZE-1:0] OP_ROL = OPSIZE'(3);
  localparam logic [OPSIZE-1:0] OP_SRA = OPSIZE'(4);

  state_t              state_q, state_d;
  logic [DSIZE-1:0]    data_q, data_d;
  logic [AWIDTH-1:0]   cnt_q, cnt_d;
  logic [OPSIZE-1:0]   op_q, op_d;
  logic                c_q, c_d;

  logic [DSIZE-1:0]    step_data;
  logic                step_bit;
  logic                accept;

  // Single 1-bit step of the latched op; unused codes fall back to SRL.
  always_comb begin
    step_data = {1'b0, data_q[DSIZE-1:1]};
    step_bit  = data_q[0];
    case (op_q)
      OP_SLL: begin
        step_data = {data_q[DSIZE-2:0], 1'b0};
        step_bit  = data_q[DSIZE-1];
      end
      OP_ROR: begin
        step_data = {data_q[0], data_q[DSIZE-1:1]};
        step_bit  = data_q[0];
      end
      OP_ROL: begin
        step_data = {data_q[DSIZE-2:0], data_q[DSIZE-1]};
        step_bit  = data_q[DSIZE-1];
      end
      OP_SRA: begin
        step_data = {data_q[DSIZE-1], data_q[DSIZE-1:1]};
        step_bit  = data_q[0];
      end
      default: begin
        step_data = {1'b0, data_q[DSIZE-1:1]};
        step_bit  = data_q[0];
      end
    endcase
  end

  // A held result retiring and a new request can share the same edge.
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    c_d     = c_q;
    case (state_q)
      S_BUSY: begin
        data_d = step_data;
        c_d    = step_bit;
        cnt_d  = cnt_q - AWIDTH'(1);
        if (cnt_q == AWIDTH'(1)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        if (accept) begin
          data_d  = data_b;
          op_d    = op;
          cnt_d   = amt;
          c_d     = 1'b0;
          state_d = (amt == '0) ? S_DONE : S_BUSY;
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      c_q     <= c_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign f         = data_q;
  assign c         = c_q;
  assign z         = ~|data_q;

endmodule

// File: doc/shifter_seq.md
Name: shifter_seq

Overview:
Multi-cycle, parametrised successor to the single-step combinational shifter. It accepts an operand, an op code and a shift amount through a valid/ready handshake. It then shifts one bit position per clock for the requested amount and returns the result through a valid/ready output handshake. The op set adds arithmetic right shift, and the block also produces carry-out and zero flags. It sits between the register file/ALU operand path and the writeback mux of the datapath.

Parameters:
DSIZE, 16, operand/result width in bits (>= 2)
OPSIZE, 3, op code width
AWIDTH, 5, shift-amount width; amounts up to 2**AWIDTH-1, may exceed DSIZE

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request this cycle
op  input  OPSIZE  operation, sampled on accept
amt  input  AWIDTH  shift amount, sampled on accept
data_b  input  DSIZE  operand, sampled on accept
out_valid  output  1  result f/c/z valid
out_ready  input  1  consumer takes result this cycle
f  output  DSIZE  result
c  output  1  last bit shifted out (0 if amt==0)
z  output  1  f == 0

Behaviour:
- Ops per 1-bit step:
  - 000 SRL: {0,d[DSIZE-1:1]}, bit out d[0]
  - 001 SLL: {d[DSIZE-2:0],0}, bit out d[DSIZE-1]
  - 010 ROR: {d[0],d[DSIZE-1:1]}, bit out d[0]
  - 011 ROL: {d[DSIZE-2:0],d[DSIZE-1]}, bit out d[DSIZE-1]
  - 100 SRA: {d[DSIZE-1],d[DSIZE-1:1]}, bit out d[0]
  - 101-111: treated as SRL
- States: IDLE, BUSY, DONE. Internal regs: data, cnt (AWIDTH), op_r, c.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational; no dependence on in_valid.
- out_valid = (state==DONE). f = data register, c = c register, z = ~|data; all registered, no combinational path from inputs.
- Accept (in_valid && in_ready):
  - data<=data_b, op_r<=op, cnt<=amt, c<=0.
  - state <= (amt==0) ? DONE : BUSY.
- BUSY, each cycle: data<=step(data), c<=bit out, cnt<=cnt-1; when cnt==1, state<=DONE.
- Latency: out_valid asserts amt+1 cycles after the accept cycle (amt=0 -> 1 cycle). Throughput: one result per amt+1 cycles.
- DONE:
  - out_ready low: f, c, z, out_valid held stable indefinitely.
  - out_ready high, no new accept: state<=IDLE.
  - out_ready and in_valid high together: result retires and new request is accepted in the same cycle (back-to-back, no bubble).
- amt >= DSIZE is legal and simply iterates:
  - SRL/SLL -> 0
  - SRA -> all sign bits
  - rotates -> amt mod DSIZE
  - c = last bit out
- in_valid during BUSY is ignored (in_ready low); inputs are not sampled.
- Reset (rst_n low, any time including mid-BUSY):
  - state=IDLE, data=0, cnt=0, op_r=0, c=0.
  - Outputs: out_valid=0, f=0, c=0, z=1, in_ready=1.
  - Any in-flight operation is discarded; no partial result is ever presented.
- After rst_n deasserts, a request may be accepted on the first clock edge.

Test Plan:
- SRL data_b=0x8001, amt=1 -> out_valid 2 cycles after accept; f=0x4000, c=1, z=0.
- SRA data_b=0x8000, amt=4 -> f=0xF800, c=0; SRA 0x0003 amt=2 -> f=0x0000, c=1, z=1.
- ROL data_b=0x8001, amt=20 -> f=0x0018 (same as amt 4), c=0; SLL 0xFFFF amt=16 -> f=0x0000, c=1.
- SLL data_b=0x1234, amt=0 -> out_valid 1 cycle after accept, f=0x1234, c=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> f/c/z/out_valid unchanged, in_ready=0. Then out_ready=1 with in_valid=1 (ROR 0x0001 amt=1) -> same-cycle accept, next result f=0x8000, c=1.
- Assert rst_n=0 mid-BUSY (SRL 0xFFFF, amt=10, after 3 cycles) -> immediately out_valid=0, f=0, z=1, in_ready=1. No result appears after release, and a fresh request completes normally.
